pll_reset_sequencer: RTL

- Sequences the two-output system PLL (50 MHz ref, 25/90 MHz outputs) from power-up to a stable running state.
  - Drives the PLL's active-high reset.
  - Qualifies the asynchronous `locked` signal.
  - Releases the system reset only after lock has been continuously stable.
- Handles lock timeout with bounded retries, and loss of lock during operation with re-sequencing.
- Runs on the free-running 50 MHz reference clock, never on a PLL output. Sits between the board reset and the PLL wrapper / per-domain reset synchronizers.

---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/pll_reset_sequencer_sync_2ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Sequencer state encoding, counter widths and a small elaboration-time helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int LOL_W   = 8;
    localparam int RETRY_W = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic 2-flop single-bit synchronizer, async active-low reset to 0.
// Shared by the PLL lock qualifier and the per-domain reset synchronizers.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two back-to-back capture stages; meta_r may go metastable, sync_r is safe to use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock / loss-of-lock reset sequencer on the free-running reference clock.
// Optional loss-of-lock event counter enabled by defining PLL_SEQ_LOL_COUNTER_EN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOL_W-1:0]   lol_cnt
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

    localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_ZERO  = {RETRY_W{1'b0}};
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    logic               lock_s;
    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_nx_s;
    logic [RETRY_W-1:0] retry_inc_s;
    logic               pll_rst_r;
    logic               sys_rst_n_r;
    logic               ready_r;
    logic               fault_r;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst),
        .d     (pll_locked),
        .q     (lock_s)
    );

    assign retry_inc_s = retry_r + RETRY_W'(1);

    // Next-state, counter and retry decisions; restart overrides every other event.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r + CNT_W'(1);
        retry_nx_s = retry_r;
        if (restart) begin
            state_nx_s = PLL_RST;
            cnt_nx_s   = CNT_ZERO;
            retry_nx_s = RETRY_ZERO;
        end else begin
            case (state_r)
                PLL_RST: begin
                    if (cnt_r == RST_LAST) begin
                        state_nx_s = WAIT_LOCK;
                        cnt_nx_s   = CNT_ZERO;
                    end else begin
                        state_nx_s = PLL_RST;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx_s = STABLE;
                        cnt_nx_s   = CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        retry_nx_s = retry_inc_s;
                        cnt_nx_s   = CNT_ZERO;
                        if (retry_inc_s == RETRY_LIMIT) begin
                            state_nx_s = FAULT;
                        end else begin
                            state_nx_s = PLL_RST;
                        end
                    end else begin
                        state_nx_s = WAIT_LOCK;
                    end
                end
                STABLE: begin
                    // A lock drop here is treated as a glitch, not a failed attempt.
                    if (!lock_s) begin
                        state_nx_s = WAIT_LOCK;
                        cnt_nx_s   = CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nx_s = RUN;
                        cnt_nx_s   = CNT_ZERO;
                        retry_nx_s = RETRY_ZERO;
                    end else begin
                        state_nx_s = STABLE;
                    end
                end
                RUN: begin
                    cnt_nx_s = CNT_ZERO;
                    if (!lock_s) begin
                        state_nx_s = PLL_RST;
                    end else begin
                        state_nx_s = RUN;
                    end
                end
                FAULT: begin
                    state_nx_s = FAULT;
                    cnt_nx_s   = CNT_ZERO;
                end
                default: begin
                    state_nx_s = PLL_RST;
                    cnt_nx_s   = CNT_ZERO;
                    retry_nx_s = RETRY_ZERO;
                end
            endcase
        end
    end

    // State, counters and outputs; outputs are decoded from next-state so they move with the state.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_r     <= PLL_RST;
            cnt_r       <= CNT_ZERO;
            retry_r     <= RETRY_ZERO;
            pll_rst_r   <= 1'b1;
            sys_rst_n_r <= 1'b0;
            ready_r     <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            retry_r     <= retry_nx_s;
            pll_rst_r   <= (state_nx_s == PLL_RST) || (state_nx_s == FAULT);
            sys_rst_n_r <= (state_nx_s == RUN);
            ready_r     <= (state_nx_s == RUN);
            fault_r     <= (state_nx_s == FAULT);
        end
    end

    assign pll_rst   = pll_rst_r;
    assign sys_rst_n = sys_rst_n_r;
    assign ready     = ready_r;
    assign fault     = fault_r;
    assign retry_cnt = retry_r;

`ifdef PLL_SEQ_LOL_COUNTER_EN
    localparam logic [LOL_W-1:0] LOL_MAX = {LOL_W{1'b1}};

    logic             lol_evt_s;
    logic [LOL_W-1:0] lol_cnt_r;

    // A restart on the same edge wins, so it is not a loss-of-lock event.
    assign lol_evt_s = !restart && (state_r == RUN) && !lock_s;

    // Saturating count of loss-of-lock exits from RUN.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            lol_cnt_r <= {LOL_W{1'b0}};
        end else if (lol_evt_s && (lol_cnt_r != LOL_MAX)) begin
            lol_cnt_r <= lol_cnt_r + LOL_W'(1);
        end else begin
            lol_cnt_r <= lol_cnt_r;
        end
    end

    assign lol_cnt = lol_cnt_r;
`else
    assign lol_cnt = {LOL_W{1'b0}};
`endif

endmodule
